// File: rtl/unidade_controle_geogenius_pkg.sv
// State codes shared by the flag-guessing game control unit and anything that decodes db_estado.
package unidade_controle_geogenius_pkg;

    localparam int unsigned EstadoW = 4;

    typedef enum logic [EstadoW-1:0] {
        INICIAL        = 4'h0,
        PREPARACAO     = 4'h1,
        MOSTRA_LED     = 4'h2,
        ESPERA_JOGADA  = 4'h3,
        REGISTRA       = 4'h4,
        COMPARA        = 4'h5,
        SOMA_SCORE     = 4'h6,
        MOSTRA_ACERTO  = 4'h7,
        MOSTRA_ERRO    = 4'h8,
        PROXIMA_JOGADA = 4'h9,
        FIM_JOGO       = 4'hA
    } estado_t;

endpackage

// File: rtl/unidade_controle_geogenius.sv
// Moore control FSM for the flag-guessing game: sequences the datapath through each round
// and keeps registered result flags for the last round played.
module unidade_controle_geogenius
    import unidade_controle_geogenius_pkg::*;
#(
    parameter bit ENCERRA_NO_ERRO = 1'b0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               iniciar,
    input  logic               fim_timer_led,
    input  logic               fim_timer_resultado,
    input  logic               deu_timeout,
    input  logic               jogada_igual_memoria,
    input  logic               ultima_jogada,
    input  logic               fez_jogada,
    output logic               zera_contador_jogada,
    output logic               zera_contador_score,
    output logic               zera_timer_led,
    output logic               zera_timer_resultado,
    output logic               zera_timeout,
    output logic               zeraR,
    output logic               conta_jogada,
    output logic               conta_score,
    output logic               conta_timer_led,
    output logic               conta_timer_resultado,
    output logic               conta_timeout,
    output logic               registraR,
    output logic               liga_led,
    output logic               acertou,
    output logic               errou,
    output logic               nao_jogou,
    output logic               pronto,
    output logic [EstadoW-1:0] db_estado
);

    estado_t estado_q, estado_d;
    logic    causa_timeout;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= INICIAL;
        end else begin
            estado_q <= estado_d;
        end
    end

    always_comb begin
        estado_d      = estado_q;
        causa_timeout = 1'b0;
        case (estado_q)
            INICIAL:       if (iniciar) estado_d = PREPARACAO;
            PREPARACAO:    estado_d = MOSTRA_LED;
            MOSTRA_LED:    if (fim_timer_led) estado_d = ESPERA_JOGADA;
            ESPERA_JOGADA: begin
                // A press in the same cycle as the timeout still counts as a play.
                if (fez_jogada) begin
                    estado_d = REGISTRA;
                end else if (deu_timeout) begin
                    estado_d      = MOSTRA_ERRO;
                    causa_timeout = 1'b1;
                end
            end
            REGISTRA:      estado_d = COMPARA;
            COMPARA:       estado_d = jogada_igual_memoria ? SOMA_SCORE : MOSTRA_ERRO;
            SOMA_SCORE:    estado_d = MOSTRA_ACERTO;
            MOSTRA_ACERTO, MOSTRA_ERRO: begin
                if (fim_timer_resultado) begin
                    if (ultima_jogada || (ENCERRA_NO_ERRO && estado_q == MOSTRA_ERRO)) begin
                        estado_d = FIM_JOGO;
                    end else begin
                        estado_d = PROXIMA_JOGADA;
                    end
                end
            end
            PROXIMA_JOGADA: estado_d = MOSTRA_LED;
            FIM_JOGO:       if (iniciar) estado_d = PREPARACAO;
            default:        estado_d = INICIAL;
        endcase
    end

    always_comb begin
        zera_contador_jogada  = 1'b0;
        zera_contador_score   = 1'b0;
        zera_timer_led        = 1'b0;
        zera_timer_resultado  = 1'b0;
        zera_timeout          = 1'b0;
        zeraR                 = 1'b0;
        conta_jogada          = 1'b0;
        conta_score           = 1'b0;
        conta_timer_led       = 1'b0;
        conta_timer_resultado = 1'b0;
        conta_timeout         = 1'b0;
        registraR             = 1'b0;
        liga_led              = 1'b0;
        pronto                = 1'b0;
        case (estado_q)
            PREPARACAO: begin
                zera_contador_jogada = 1'b1;
                zera_contador_score  = 1'b1;
                zera_timer_led       = 1'b1;
                zera_timer_resultado = 1'b1;
                zera_timeout         = 1'b1;
                zeraR                = 1'b1;
            end
            MOSTRA_LED: begin
                liga_led        = 1'b1;
                conta_timer_led = 1'b1;
            end
            ESPERA_JOGADA:              conta_timeout         = 1'b1;
            REGISTRA:                   registraR             = 1'b1;
            SOMA_SCORE:                 conta_score           = 1'b1;
            MOSTRA_ACERTO, MOSTRA_ERRO: conta_timer_resultado = 1'b1;
            PROXIMA_JOGADA: begin
                conta_jogada         = 1'b1;
                zera_timer_led       = 1'b1;
                zera_timer_resultado = 1'b1;
                zera_timeout         = 1'b1;
                zeraR                = 1'b1;
            end
            FIM_JOGO:                   pronto                = 1'b1;
            default: ;
        endcase
    end

    // Flags change only on state entry so they hold through FIM_JOGO.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acertou   <= 1'b0;
            errou     <= 1'b0;
            nao_jogou <= 1'b0;
        end else if (estado_d != estado_q) begin
            case (estado_d)
                PREPARACAO, PROXIMA_JOGADA: begin
                    acertou   <= 1'b0;
                    errou     <= 1'b0;
                    nao_jogou <= 1'b0;
                end
                MOSTRA_ACERTO: begin
                    acertou   <= 1'b1;
                    errou     <= 1'b0;
                    nao_jogou <= 1'b0;
                end
                MOSTRA_ERRO: begin
                    acertou   <= 1'b0;
                    errou     <= 1'b1;
                    nao_jogou <= causa_timeout;
                end
                default: ;
            endcase
        end
    end

    assign db_estado = estado_q;

endmodule

// File: tb/tb_unidade_controle_geogenius.sv
// Self-checking bench for the game control unit: expected state sequences are queued per
// scenario and popped against db_estado each clock, for both values of ENCERRA_NO_ERRO.
module tb_unidade_controle_geogenius;
    import unidade_controle_geogenius_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic iniciar = 1'b0, fim_timer_led = 1'b0, fim_timer_resultado = 1'b0;
    logic deu_timeout = 1'b0, jogada_igual_memoria = 1'b0, ultima_jogada = 1'b0;
    logic fez_jogada = 1'b0;

    logic zera_contador_jogada, zera_contador_score, zera_timer_led, zera_timer_resultado;
    logic zera_timeout, zeraR, conta_jogada, conta_score, conta_timer_led;
    logic conta_timer_resultado, conta_timeout, registraR, liga_led;
    logic acertou, errou, nao_jogou, pronto;
    logic [3:0] db_estado;

    logic zcj_e, zcs_e, ztl_e, ztr_e, zto_e, zr_e, cj_e, cs_e, ctl_e, ctr_e, cto_e, rr_e, ll_e;
    logic acertou_e, errou_e, nao_jogou_e, pronto_e;
    logic [3:0] db_estado_e;

    int tests_run = 0;
    int tests_failed = 0;
    logic [3:0] exp_q[$];
    logic [3:0] exp_e_q[$];

    always #5 clock = ~clock;

    unidade_controle_geogenius #(.ENCERRA_NO_ERRO(1'b0)) u_dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .fim_timer_led(fim_timer_led),
        .fim_timer_resultado(fim_timer_resultado), .deu_timeout(deu_timeout),
        .jogada_igual_memoria(jogada_igual_memoria), .ultima_jogada(ultima_jogada),
        .fez_jogada(fez_jogada), .zera_contador_jogada(zera_contador_jogada),
        .zera_contador_score(zera_contador_score), .zera_timer_led(zera_timer_led),
        .zera_timer_resultado(zera_timer_resultado), .zera_timeout(zera_timeout),
        .zeraR(zeraR), .conta_jogada(conta_jogada), .conta_score(conta_score),
        .conta_timer_led(conta_timer_led), .conta_timer_resultado(conta_timer_resultado),
        .conta_timeout(conta_timeout), .registraR(registraR), .liga_led(liga_led),
        .acertou(acertou), .errou(errou), .nao_jogou(nao_jogou), .pronto(pronto),
        .db_estado(db_estado)
    );

    unidade_controle_geogenius #(.ENCERRA_NO_ERRO(1'b1)) u_dut_enc (
        .clock(clock), .reset(reset), .iniciar(iniciar), .fim_timer_led(fim_timer_led),
        .fim_timer_resultado(fim_timer_resultado), .deu_timeout(deu_timeout),
        .jogada_igual_memoria(jogada_igual_memoria), .ultima_jogada(ultima_jogada),
        .fez_jogada(fez_jogada), .zera_contador_jogada(zcj_e), .zera_contador_score(zcs_e),
        .zera_timer_led(ztl_e), .zera_timer_resultado(ztr_e), .zera_timeout(zto_e),
        .zeraR(zr_e), .conta_jogada(cj_e), .conta_score(cs_e), .conta_timer_led(ctl_e),
        .conta_timer_resultado(ctr_e), .conta_timeout(cto_e), .registraR(rr_e),
        .liga_led(ll_e), .acertou(acertou_e), .errou(errou_e), .nao_jogou(nao_jogou_e),
        .pronto(pronto_e), .db_estado(db_estado_e)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        iniciar = 1'b0; fim_timer_led = 1'b0; fim_timer_resultado = 1'b0;
        deu_timeout = 1'b0; jogada_igual_memoria = 1'b0; ultima_jogada = 1'b0;
        fez_jogada = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] exp;
        clear_inputs();
        reset = 1'b0;
        tick();
        tick();
        tests_run++;
        if (db_estado !== 4'h0 || {acertou, errou, nao_jogou, pronto} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_state: got estado=%h flags=%b want 0 / 0000", db_estado,
                     {acertou, errou, nao_jogou, pronto});
        end
        reset = 1'b1;
        tick();
        exp = INICIAL;
        tests_run++;
        if (db_estado !== exp) begin
            tests_failed++;
            $display("FAIL idle_hold: got %h want %h", db_estado, exp);
        end
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        exp = PREPARACAO;
        tests_run++;
        if (db_estado !== exp || {zera_contador_jogada, zera_contador_score, zera_timer_led,
                                  zera_timer_resultado, zera_timeout, zeraR} !== 6'h3f) begin
            tests_failed++;
            $display("FAIL preparacao: got estado=%h zeras=%b want %h / 111111", db_estado,
                     {zera_contador_jogada, zera_contador_score, zera_timer_led,
                      zera_timer_resultado, zera_timeout, zeraR}, exp);
        end
        tick();
        exp = MOSTRA_LED;
        tests_run++;
        if (db_estado !== exp || {liga_led, conta_timer_led} !== 2'b11) begin
            tests_failed++;
            $display("FAIL mostra_led: got estado=%h led/cnt=%b want %h / 11", db_estado,
                     {liga_led, conta_timer_led}, exp);
        end
        // Asynchronous reset in the middle of the clock-high phase.
        #3 reset = 1'b0;
        #1;
        tests_run++;
        if (db_estado !== 4'h0 || {liga_led, conta_timer_led} !== 2'b00) begin
            tests_failed++;
            $display("FAIL async_reset: got estado=%h led/cnt=%b want 0 / 00", db_estado,
                     {liga_led, conta_timer_led});
        end
        tick();
        reset = 1'b1;
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        exp = PREPARACAO;
        tests_run++;
        if (db_estado !== exp) begin
            tests_failed++;
            $display("FAIL restart_prep: got %h want %h", db_estado, exp);
        end
        tick();
        exp = MOSTRA_LED;
        tests_run++;
        if (db_estado !== exp) begin
            tests_failed++;
            $display("FAIL restart_led: got %h want %h", db_estado, exp);
        end
    endtask

    task automatic test_correct_round();
        logic [3:0] exp;
        int n_score = 0;
        int n_jogada = 0;
        fim_timer_led = 1'b1; fez_jogada = 1'b1; jogada_igual_memoria = 1'b1;
        fim_timer_resultado = 1'b1; ultima_jogada = 1'b0;
        exp_q.delete();
        exp_q.push_back(ESPERA_JOGADA); exp_q.push_back(REGISTRA);
        exp_q.push_back(COMPARA);       exp_q.push_back(SOMA_SCORE);
        exp_q.push_back(MOSTRA_ACERTO); exp_q.push_back(PROXIMA_JOGADA);
        exp_q.push_back(MOSTRA_LED);
        while (exp_q.size() > 0) begin
            tick();
            exp = exp_q.pop_front();
            if (conta_score) n_score++;
            if (conta_jogada) n_jogada++;
            tests_run++;
            if (db_estado !== exp) begin
                tests_failed++;
                $display("FAIL correct_round state: got %h want %h", db_estado, exp);
            end
            if (exp == MOSTRA_ACERTO) begin
                tests_run++;
                if ({acertou, errou, nao_jogou} !== 3'b100) begin
                    tests_failed++;
                    $display("FAIL correct_round flags: got %b want 100",
                             {acertou, errou, nao_jogou});
                end
            end
        end
        clear_inputs();
        tests_run++;
        if (n_score != 1 || n_jogada != 1) begin
            tests_failed++;
            $display("FAIL correct_round counts: got score=%0d jogada=%0d want 1/1",
                     n_score, n_jogada);
        end
        tests_run++;
        if ({acertou, errou, nao_jogou} !== 3'b000) begin
            tests_failed++;
            $display("FAIL correct_round clear: got %b want 000", {acertou, errou, nao_jogou});
        end
    endtask

    task automatic test_timeout_round();
        logic [3:0] exp;
        int n_score = 0;
        fim_timer_led = 1'b1; deu_timeout = 1'b1;
        exp_q.delete();
        exp_q.push_back(ESPERA_JOGADA); exp_q.push_back(MOSTRA_ERRO);
        while (exp_q.size() > 0) begin
            tick();
            exp = exp_q.pop_front();
            if (conta_score) n_score++;
            tests_run++;
            if (db_estado !== exp) begin
                tests_failed++;
                $display("FAIL timeout_round state: got %h want %h", db_estado, exp);
            end
        end
        tests_run++;
        if ({acertou, errou, nao_jogou} !== 3'b011) begin
            tests_failed++;
            $display("FAIL timeout_round flags: got %b want 011", {acertou, errou, nao_jogou});
        end
        clear_inputs();
        fim_timer_resultado = 1'b1;
        exp_q.push_back(PROXIMA_JOGADA); exp_q.push_back(MOSTRA_LED);
        while (exp_q.size() > 0) begin
            tick();
            exp = exp_q.pop_front();
            if (conta_score) n_score++;
            tests_run++;
            if (db_estado !== exp) begin
                tests_failed++;
                $display("FAIL timeout_next state: got %h want %h", db_estado, exp);
            end
        end
        clear_inputs();
        tests_run++;
        if (n_score != 0 || {acertou, errou, nao_jogou} !== 3'b000) begin
            tests_failed++;
            $display("FAIL timeout_round score/clear: got score=%0d flags=%b want 0 / 000",
                     n_score, {acertou, errou, nao_jogou});
        end
    endtask

    task automatic test_press_and_timeout_last_round();
        logic [3:0] exp;
        fim_timer_led = 1'b1; fez_jogada = 1'b1; deu_timeout = 1'b1;
        exp_q.delete();
        exp_q.push_back(ESPERA_JOGADA); exp_q.push_back(REGISTRA);
        while (exp_q.size() > 0) begin
            tick();
            exp = exp_q.pop_front();
            tests_run++;
            if (db_estado !== exp) begin
                tests_failed++;
                $display("FAIL press_wins state: got %h want %h", db_estado, exp);
            end
        end
        tests_run++;
        if (nao_jogou !== 1'b0 || registraR !== 1'b1) begin
            tests_failed++;
            $display("FAIL press_wins outs: got nao_jogou=%b registraR=%b want 0/1",
                     nao_jogou, registraR);
        end
        clear_inputs();
        jogada_igual_memoria = 1'b1; ultima_jogada = 1'b1; fim_timer_resultado = 1'b1;
        exp_q.push_back(COMPARA);       exp_q.push_back(SOMA_SCORE);
        exp_q.push_back(MOSTRA_ACERTO); exp_q.push_back(FIM_JOGO);
        exp_q.push_back(FIM_JOGO);
        while (exp_q.size() > 0) begin
            tick();
            exp = exp_q.pop_front();
            tests_run++;
            if (db_estado !== exp) begin
                tests_failed++;
                $display("FAIL last_round state: got %h want %h", db_estado, exp);
            end
        end
        tests_run++;
        if ({pronto, acertou, errou, nao_jogou} !== 4'b1100) begin
            tests_failed++;
            $display("FAIL last_round fim: got pronto/flags=%b want 1100",
                     {pronto, acertou, errou, nao_jogou});
        end
        // Held iniciar restarts once; stray presses outside ESPERA_JOGADA do nothing.
        clear_inputs();
        iniciar = 1'b1; fez_jogada = 1'b1;
        exp_q.push_back(PREPARACAO); exp_q.push_back(MOSTRA_LED); exp_q.push_back(MOSTRA_LED);
        while (exp_q.size() > 0) begin
            tick();
            exp = exp_q.pop_front();
            tests_run++;
            if (db_estado !== exp) begin
                tests_failed++;
                $display("FAIL restart_held state: got %h want %h", db_estado, exp);
            end
            if (exp == PREPARACAO) begin
                tests_run++;
                if ({pronto, acertou, errou, nao_jogou} !== 4'b0000) begin
                    tests_failed++;
                    $display("FAIL restart_held clear: got %b want 0000",
                             {pronto, acertou, errou, nao_jogou});
                end
            end
        end
        clear_inputs();
    endtask

    task automatic test_encerra_no_erro();
        logic [3:0] exp;
        logic [3:0] exp_e;
        clear_inputs();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        tick();
        exp = MOSTRA_LED;
        tests_run++;
        if (db_estado !== exp || db_estado_e !== exp) begin
            tests_failed++;
            $display("FAIL encerra_setup: got %h/%h want %h", db_estado, db_estado_e, exp);
        end
        fim_timer_led = 1'b1; fez_jogada = 1'b1; jogada_igual_memoria = 1'b0;
        fim_timer_resultado = 1'b1; ultima_jogada = 1'b0;
        exp_q.delete();
        exp_e_q.delete();
        exp_q.push_back(ESPERA_JOGADA); exp_q.push_back(REGISTRA); exp_q.push_back(COMPARA);
        exp_q.push_back(MOSTRA_ERRO);   exp_q.push_back(PROXIMA_JOGADA);
        exp_e_q.push_back(ESPERA_JOGADA); exp_e_q.push_back(REGISTRA);
        exp_e_q.push_back(COMPARA);       exp_e_q.push_back(MOSTRA_ERRO);
        exp_e_q.push_back(FIM_JOGO);
        while (exp_q.size() > 0 && exp_e_q.size() > 0) begin
            tick();
            exp = exp_q.pop_front();
            exp_e = exp_e_q.pop_front();
            tests_run++;
            if (db_estado !== exp) begin
                tests_failed++;
                $display("FAIL continua_no_erro state: got %h want %h", db_estado, exp);
            end
            tests_run++;
            if (db_estado_e !== exp_e) begin
                tests_failed++;
                $display("FAIL encerra_no_erro state: got %h want %h", db_estado_e, exp_e);
            end
            if (exp_e == MOSTRA_ERRO) begin
                tests_run++;
                if ({acertou_e, errou_e, nao_jogou_e} !== 3'b010) begin
                    tests_failed++;
                    $display("FAIL encerra_no_erro flags: got %b want 010",
                             {acertou_e, errou_e, nao_jogou_e});
                end
            end
        end
        tests_run++;
        if (pronto_e !== 1'b1 || errou_e !== 1'b1 || pronto !== 1'b0) begin
            tests_failed++;
            $display("FAIL encerra_no_erro fim: got pronto_e=%b errou_e=%b pronto=%b want 1/1/0",
                     pronto_e, errou_e, pronto);
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_correct_round();
        test_timeout_round();
        test_press_and_timeout_last_round();
        test_encerra_no_erro();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/unidade_controle_geogenius.md
Name: unidade_controle_geogenius

Overview:
Control unit for the flag-guessing game. It consumes the datapath status outputs (timer ends, timeout, compare result, last-round, button pulse) and drives every datapath zera/conta/registra/liga control. A round runs: show flag, wait for a press or timeout, compare, show result, then advance. It sits beside the datapath in the game top level and also exports a debug state code and result flags.

Parameters:
ENCERRA_NO_ERRO, 0, when 1 a wrong answer or timeout ends the game after the result display; when 0 play continues to the last round.

Ports:
clock  in  1  system clock, all state updates on the rising edge
reset  in  1  asynchronous, active-low; 0 forces IDLE state and clears flags immediately
iniciar  in  1  start or restart request, sampled in INICIAL and FIM_JOGO
fim_timer_led  in  1  flag-display timer reached its end
fim_timer_resultado  in  1  result-display timer reached its end
deu_timeout  in  1  answer timeout expired
jogada_igual_memoria  in  1  registered press matches the ROM entry
ultima_jogada  in  1  current round index is the last for the selected difficulty
fez_jogada  in  1  one-cycle button-press pulse
zera_contador_jogada, zera_contador_score, zera_timer_led, zera_timer_resultado, zera_timeout, zeraR  out  1 each  datapath clears
conta_jogada, conta_score, conta_timer_led, conta_timer_resultado, conta_timeout  out  1 each  datapath count enables
registraR  out  1  load the button register
liga_led  out  1  enable the flag LEDs
acertou  out  1  registered; last round correct
errou  out  1  registered; last round wrong or timed out
nao_jogou  out  1  registered; last round ended by timeout
pronto  out  1  game finished
db_estado  out  4  current state code

Behaviour:
- Moore FSM with a 4-bit state register. Control outputs decode from state only. Outputs are 0 in any state that does not list them.
- INICIAL (0): all outputs 0. iniciar=1 -> PREPARACAO.
- PREPARACAO (1), 1 cycle: assert all six zera_* outputs -> MOSTRA_LED.
- MOSTRA_LED (2): liga_led=1, conta_timer_led=1. fim_timer_led=1 -> ESPERA_JOGADA.
- ESPERA_JOGADA (3): conta_timeout=1.
  - fez_jogada=1 -> REGISTRA.
  - else deu_timeout=1 -> MOSTRA_ERRO with the timeout cause.
  - If both are 1 in the same cycle, fez_jogada wins.
- REGISTRA (4), 1 cycle: registraR=1 -> COMPARA.
- COMPARA (5), 1 cycle: jogada_igual_memoria=1 -> SOMA_SCORE, else -> MOSTRA_ERRO. The register loaded in REGISTRA is valid here.
- SOMA_SCORE (6), 1 cycle: conta_score=1 -> MOSTRA_ACERTO. Exactly one score increment per correct round.
- MOSTRA_ACERTO (7) and MOSTRA_ERRO (8): conta_timer_resultado=1. On fim_timer_resultado=1:
  - -> FIM_JOGO if ultima_jogada=1, or if ENCERRA_NO_ERRO=1 and the state is MOSTRA_ERRO.
  - else -> PROXIMA_JOGADA.
- PROXIMA_JOGADA (9), 1 cycle: conta_jogada, zera_timer_led, zera_timer_resultado, zera_timeout and zeraR all =1 -> MOSTRA_LED. The ROM address advances here; its output is valid before any LED is sampled.
- FIM_JOGO (A): pronto=1, with acertou/errou/nao_jogou holding the last round. iniciar=1 -> PREPARACAO.
- Codes B-F -> INICIAL on the next clock.
- Flags are registered:
  - acertou is set on entry to MOSTRA_ACERTO.
  - errou is set on entry to MOSTRA_ERRO.
  - nao_jogou is set together with errou only when the cause is timeout.
  - All three clear on entry to PREPARACAO or PROXIMA_JOGADA.
  - acertou and errou are never both 1.
- Reset: async assertion at any time gives state INICIAL, db_estado=0 and all flags 0. Outputs are 0 in the same instant; no datapath pulse completes. Release is synchronous to clock.
- Held levels: iniciar held high in FIM_JOGO restarts exactly once per visit. fez_jogada outside ESPERA_JOGADA is ignored.

Decomposition:
- Shared package: 4-bit state code constants (INICIAL..FIM_JOGO) and the state width.
- The top level and the bench decode db_estado with the same constants.
- Single module, no sub-module; the next-state, output-decode and flag logic are small enough to stay flat.

Test Plan:
- Reset low mid-MOSTRA_LED -> db_estado=0 and all outputs 0 without waiting for a clock. Release then iniciar=1 -> PREPARACAO for 1 cycle with all zera_*=1, then db_estado=2.
- Correct round: fim_timer_led, fez_jogada, jogada_igual_memoria=1, fim_timer_resultado, ultima_jogada=0 -> states 2,3,4,5,6,7,9,2. conta_score=1 for exactly 1 cycle, acertou=1 during 7, conta_jogada=1 once.
- Timeout round: deu_timeout=1 in state 3 -> state 8, errou=1, nao_jogou=1, conta_score never 1.
- fez_jogada and deu_timeout both 1 in state 3 -> REGISTRA (4), nao_jogou=0.
- Last round with ultima_jogada=1 at fim_timer_resultado -> FIM_JOGO (A), pronto=1. iniciar=1 -> PREPARACAO and flags cleared.
- ENCERRA_NO_ERRO=1, wrong answer (jogada_igual_memoria=0) with ultima_jogada=0 -> 5,8,A. With ENCERRA_NO_ERRO=0 the same stimulus -> 5,8,9.
